// File: rtl/cpu_bus_arbiter_if.sv
// cpu_bus_arbiter_if: requester ports A/B, system-bus master signals and watchdog flag of the arbiter.
interface cpu_bus_arbiter_if;
  logic        i_a_request;
  logic [31:0] i_a_address;
  logic        o_a_ready;
  logic [31:0] o_a_rdata;
  logic        i_b_rw;
  logic        i_b_request;
  logic [31:0] i_b_address;
  logic [31:0] i_b_wdata;
  logic [3:0]  i_b_wmask;
  logic        o_b_ready;
  logic [31:0] o_b_rdata;
  logic        o_bus_rw;
  logic        o_bus_request;
  logic [31:0] o_bus_address;
  logic [31:0] o_bus_wdata;
  logic [3:0]  o_bus_wmask;
  logic        i_bus_ready;
  logic [31:0] i_bus_rdata;
  logic        o_timeout;
  modport slave (
    input  i_a_request, i_a_address, i_b_rw, i_b_request, i_b_address, i_b_wdata, i_b_wmask,
    input  i_bus_ready, i_bus_rdata,
    output o_a_ready, o_a_rdata, o_b_ready, o_b_rdata,
    output o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata, o_bus_wmask, o_timeout
  );
  modport master (
    output i_a_request, i_a_address, i_b_rw, i_b_request, i_b_address, i_b_wdata, i_b_wmask,
    output i_bus_ready, i_bus_rdata,
    input  o_a_ready, o_a_rdata, o_b_ready, o_b_rdata,
    input  o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata, o_bus_wmask, o_timeout
  );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: shares one bus master port between fetch (A) and data (B), B-priority with starvation bound and watchdog.
module cpu_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 1023
) (
  input logic              i_clock,
  input logic              i_reset,
  cpu_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;
  localparam logic [7:0]  LIMIT = 8'(STARVE_LIMIT);
  localparam logic [15:0] TMO   = 16'(TIMEOUT);
  state_t      state_q, state_d;
  logic [7:0]  starve_q, starve_d;
  logic [15:0] wdog_q, wdog_d;
  logic        timeout_q, timeout_d;
  logic        grant_a, grant_b, take_b, x_req;
  assign grant_a = state_q == GRANT_A;
  assign grant_b = state_q == GRANT_B;
  assign bus.o_bus_request = (grant_a & bus.i_a_request) | (grant_b & bus.i_b_request);
  assign bus.o_bus_rw      = grant_b & bus.i_b_rw;
  assign bus.o_bus_address = grant_a ? bus.i_a_address : grant_b ? bus.i_b_address : 32'd0;
  assign bus.o_bus_wdata   = grant_b ? bus.i_b_wdata : 32'd0;
  assign bus.o_bus_wmask   = grant_b ? bus.i_b_wmask : 4'd0;
  assign bus.o_a_ready     = grant_a & bus.i_bus_ready & bus.i_a_request;
  assign bus.o_b_ready     = grant_b & bus.i_bus_ready & bus.i_b_request;
  assign bus.o_a_rdata     = bus.i_bus_rdata;
  assign bus.o_b_rdata     = bus.i_bus_rdata;
  assign bus.o_timeout     = timeout_q;
  // B only counts up while A waits, and B is refused at the limit, so the count never passes LIMIT
  always_comb begin
    take_b    = bus.i_b_request & ~(bus.i_a_request & (starve_q == LIMIT));
    x_req     = grant_a ? bus.i_a_request : bus.i_b_request;
    state_d   = state_q;
    starve_d  = starve_q;
    if (state_q == IDLE) begin
      state_d  = take_b ? GRANT_B : bus.i_a_request ? GRANT_A : IDLE;
      starve_d = take_b ? starve_q + {7'd0, bus.i_a_request} : bus.i_a_request ? 8'd0 : starve_q;
    end else if (bus.i_bus_ready | ~x_req) begin
      state_d = IDLE;
    end
    wdog_d    = (state_q == IDLE || bus.i_bus_ready) ? 16'd0 : wdog_q + {15'd0, wdog_q != 16'hFFFF};
    timeout_d = timeout_q | (wdog_d == TMO);
  end
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      starve_q  <= 8'd0;
      wdog_q    <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb_cpu_bus_arbiter: directed scenarios plus a random run checked against a transaction-level arbiter model.
module tb_cpu_bus_arbiter;
  localparam int LIMIT = 4;
  localparam int TMO   = 8;
  logic i_clock = 1'b0;
  logic i_reset = 1'b0;
  int   n_cmp   = 0;
  int   n_err   = 0;
  cpu_bus_arbiter_if ifc();
  cpu_bus_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT(TMO)) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .bus    (ifc.slave)
  );
  always #5 i_clock = ~i_clock;
  initial begin
    #1_000_000;
    $display("FAIL sim_time_limit: run did not finish within 1000000 time units");
    $fatal(1);
  end
  task automatic clr();
    ifc.i_a_request = 1'b0;
    ifc.i_a_address = 32'd0;
    ifc.i_b_rw      = 1'b0;
    ifc.i_b_request = 1'b0;
    ifc.i_b_address = 32'd0;
    ifc.i_b_wdata   = 32'd0;
    ifc.i_b_wmask   = 4'd0;
    ifc.i_bus_ready = 1'b0;
    ifc.i_bus_rdata = 32'd0;
  endtask
  task automatic next();
    @(posedge i_clock);
    #1;
  endtask
  task automatic do_reset();
    clr();
    #2 i_reset = 1'b0;
    #10;
    @(negedge i_clock);
    i_reset = 1'b1;
  endtask
  task automatic test_reset();
    clr();
    i_reset = 1'b0;
    ifc.i_bus_rdata = 32'h1234_5678;
    ifc.i_bus_ready = 1'b1;
    ifc.i_a_request = 1'b1;
    ifc.i_b_request = 1'b1;
    @(posedge i_clock);
    #3;
    n_cmp++;
    if ({ifc.o_bus_request, ifc.o_bus_rw, ifc.o_bus_address, ifc.o_bus_wdata, ifc.o_bus_wmask,
         ifc.o_a_ready, ifc.o_b_ready, ifc.o_timeout} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got req=%b addr=%h ardy=%b brdy=%b tmo=%b, want all 0",
               ifc.o_bus_request, ifc.o_bus_address, ifc.o_a_ready, ifc.o_b_ready, ifc.o_timeout);
    end
    n_cmp++;
    if (ifc.o_a_rdata !== 32'h1234_5678 || ifc.o_b_rdata !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL reset_rdata: got a=%h b=%h, want 12345678", ifc.o_a_rdata, ifc.o_b_rdata);
    end
    do_reset();
  endtask
  task automatic test_single_a();
    do_reset();
    next();
    ifc.i_a_request = 1'b1;
    ifc.i_a_address = 32'h0000_1000;
    @(negedge i_clock);
    n_cmp++;
    if (ifc.o_bus_request !== 1'b0) begin
      n_err++;
      $display("FAIL single_a_c0: bus_request=%b, want 0", ifc.o_bus_request);
    end
    for (int c = 1; c <= 3; c++) begin
      next();
      ifc.i_bus_ready = (c == 3);
      ifc.i_bus_rdata = (c == 3) ? 32'hDEAD_BEEF : 32'h0;
      @(negedge i_clock);
      n_cmp++;
      if ({ifc.o_bus_request, ifc.o_bus_rw, ifc.o_bus_address} !== {1'b1, 1'b0, 32'h0000_1000}) begin
        n_err++;
        $display("FAIL single_a_bus c%0d: req=%b rw=%b addr=%h, want 1 0 00001000",
                 c, ifc.o_bus_request, ifc.o_bus_rw, ifc.o_bus_address);
      end
      n_cmp++;
      if (ifc.o_a_ready !== (c == 3) || ifc.o_b_ready !== 1'b0) begin
        n_err++;
        $display("FAIL single_a_ready c%0d: a=%b b=%b, want a=%b b=0", c, ifc.o_a_ready, ifc.o_b_ready, c == 3);
      end
      if (c == 3) begin
        n_cmp++;
        if (ifc.o_a_rdata !== 32'hDEAD_BEEF) begin
          n_err++;
          $display("FAIL single_a_rdata: got %h, want deadbeef", ifc.o_a_rdata);
        end
      end
    end
    next();
    ifc.i_bus_ready = 1'b0;
    ifc.i_a_address = 32'h0000_2000;
    @(negedge i_clock);
    n_cmp++;
    if (ifc.o_bus_request !== 1'b0 || ifc.o_a_ready !== 1'b0) begin
      n_err++;
      $display("FAIL single_a_bubble: req=%b ardy=%b, want 0 0", ifc.o_bus_request, ifc.o_a_ready);
    end
    next();
    ifc.i_bus_ready = 1'b1;
    @(negedge i_clock);
    n_cmp++;
    if ({ifc.o_bus_request, ifc.o_bus_address, ifc.o_a_ready} !== {1'b1, 32'h0000_2000, 1'b1}) begin
      n_err++;
      $display("FAIL single_a_second: req=%b addr=%h ardy=%b, want 1 00002000 1",
               ifc.o_bus_request, ifc.o_bus_address, ifc.o_a_ready);
    end
    next();
    clr();
  endtask
  task automatic test_simultaneous();
    do_reset();
    next();
    ifc.i_a_request = 1'b1;
    ifc.i_a_address = 32'h100;
    ifc.i_b_request = 1'b1;
    ifc.i_b_rw      = 1'b1;
    ifc.i_b_address = 32'h200;
    ifc.i_b_wdata   = 32'h55;
    ifc.i_b_wmask   = 4'hF;
    next();
    ifc.i_bus_ready = 1'b1;
    @(negedge i_clock);
    n_cmp++;
    if ({ifc.o_bus_request, ifc.o_bus_rw, ifc.o_bus_address, ifc.o_bus_wdata, ifc.o_bus_wmask}
        !== {1'b1, 1'b1, 32'h200, 32'h55, 4'hF}) begin
      n_err++;
      $display("FAIL simul_b_first: req=%b rw=%b addr=%h wdata=%h wmask=%h, want 1 1 200 55 f",
               ifc.o_bus_request, ifc.o_bus_rw, ifc.o_bus_address, ifc.o_bus_wdata, ifc.o_bus_wmask);
    end
    n_cmp++;
    if (ifc.o_b_ready !== 1'b1 || ifc.o_a_ready !== 1'b0) begin
      n_err++;
      $display("FAIL simul_b_ready: a=%b b=%b, want a=0 b=1", ifc.o_a_ready, ifc.o_b_ready);
    end
    next();
    ifc.i_b_request = 1'b0;
    @(negedge i_clock);
    n_cmp++;
    if (ifc.o_bus_request !== 1'b0 || ifc.o_a_ready !== 1'b0 || ifc.o_b_ready !== 1'b0) begin
      n_err++;
      $display("FAIL simul_idle_ready_ignored: req=%b a=%b b=%b, want 0 0 0",
               ifc.o_bus_request, ifc.o_a_ready, ifc.o_b_ready);
    end
    next();
    @(negedge i_clock);
    n_cmp++;
    if ({ifc.o_bus_request, ifc.o_bus_rw, ifc.o_bus_address, ifc.o_bus_wdata, ifc.o_bus_wmask, ifc.o_a_ready}
        !== {1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b1}) begin
      n_err++;
      $display("FAIL simul_a_c3: req=%b rw=%b addr=%h wdata=%h wmask=%h ardy=%b, want 1 0 100 0 0 1",
               ifc.o_bus_request, ifc.o_bus_rw, ifc.o_bus_address, ifc.o_bus_wdata, ifc.o_bus_wmask, ifc.o_a_ready);
    end
    next();
    clr();
  endtask
  task automatic test_starvation();
    int gi;
    gi = 0;
    do_reset();
    next();
    ifc.i_a_request = 1'b1;
    ifc.i_a_address = 32'hA0;
    ifc.i_b_request = 1'b1;
    ifc.i_b_rw      = 1'b1;
    ifc.i_b_address = 32'hB0;
    ifc.i_bus_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clock);
      if (ifc.o_bus_request === 1'b1) begin
        n_cmp++;
        if (ifc.o_bus_address !== ((gi % (LIMIT + 1) == LIMIT) ? 32'hA0 : 32'hB0)) begin
          n_err++;
          $display("FAIL starve_grant%0d: addr=%h, want %h", gi, ifc.o_bus_address,
                   (gi % (LIMIT + 1) == LIMIT) ? 32'hA0 : 32'hB0);
        end
        gi++;
      end
    end
    n_cmp++;
    if (gi != 20) begin
      n_err++;
      $display("FAIL starve_grant_count: got %0d grants, want 20", gi);
    end
    next();
    clr();
  endtask
  task automatic test_abort();
    do_reset();
    next();
    ifc.i_b_request = 1'b1;
    ifc.i_b_address = 32'h300;
    @(negedge i_clock);
    n_cmp++;
    if (ifc.o_bus_request !== 1'b0) begin
      n_err++;
      $display("FAIL abort_c0: req=%b, want 0", ifc.o_bus_request);
    end
    next();
    ifc.i_a_request = 1'b1;
    ifc.i_a_address = 32'h400;
    @(negedge i_clock);
    n_cmp++;
    if ({ifc.o_bus_request, ifc.o_bus_rw, ifc.o_bus_address} !== {1'b1, 1'b0, 32'h300}) begin
      n_err++;
      $display("FAIL abort_c1: req=%b rw=%b addr=%h, want 1 0 300", ifc.o_bus_request, ifc.o_bus_rw, ifc.o_bus_address);
    end
    next();
    ifc.i_b_request = 1'b0;
    @(negedge i_clock);
    n_cmp++;
    if ({ifc.o_bus_request, ifc.o_a_ready, ifc.o_b_ready} !== 3'b000) begin
      n_err++;
      $display("FAIL abort_c2: req=%b a=%b b=%b, want 0 0 0", ifc.o_bus_request, ifc.o_a_ready, ifc.o_b_ready);
    end
    next();
    @(negedge i_clock);
    n_cmp++;
    if (ifc.o_bus_request !== 1'b0) begin
      n_err++;
      $display("FAIL abort_c3_idle: req=%b, want 0", ifc.o_bus_request);
    end
    next();
    ifc.i_bus_ready = 1'b1;
    @(negedge i_clock);
    n_cmp++;
    if ({ifc.o_bus_request, ifc.o_bus_address, ifc.o_a_ready} !== {1'b1, 32'h400, 1'b1}) begin
      n_err++;
      $display("FAIL abort_c4_grant_a: req=%b addr=%h ardy=%b, want 1 400 1",
               ifc.o_bus_request, ifc.o_bus_address, ifc.o_a_ready);
    end
    next();
    clr();
  endtask
  task automatic test_watchdog();
    do_reset();
    next();
    ifc.i_a_request = 1'b1;
    ifc.i_a_address = 32'h500;
    @(negedge i_clock);
    n_cmp++;
    if (ifc.o_timeout !== 1'b0 || ifc.o_bus_request !== 1'b0) begin
      n_err++;
      $display("FAIL wdog_c0: tmo=%b req=%b, want 0 0", ifc.o_timeout, ifc.o_bus_request);
    end
    for (int c = 1; c <= 12; c++) begin
      @(negedge i_clock);
      n_cmp++;
      if (ifc.o_timeout !== (c > TMO) || ifc.o_bus_request !== 1'b1) begin
        n_err++;
        $display("FAIL wdog_c%0d: tmo=%b req=%b, want tmo=%b req=1", c, ifc.o_timeout, ifc.o_bus_request, c > TMO);
      end
    end
    next();
    ifc.i_bus_ready = 1'b1;
    @(negedge i_clock);
    n_cmp++;
    if (ifc.o_a_ready !== 1'b1 || ifc.o_timeout !== 1'b1) begin
      n_err++;
      $display("FAIL wdog_complete: ardy=%b tmo=%b, want 1 1", ifc.o_a_ready, ifc.o_timeout);
    end
    next();
    clr();
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clock);
      n_cmp++;
      if (ifc.o_timeout !== 1'b1) begin
        n_err++;
        $display("FAIL wdog_sticky%0d: tmo=%b, want 1", c, ifc.o_timeout);
      end
    end
    #2 i_reset = 1'b0;
    #1;
    n_cmp++;
    if (ifc.o_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL wdog_reset_clear: tmo=%b, want 0", ifc.o_timeout);
    end
    @(negedge i_clock);
    i_reset = 1'b1;
  endtask
  task automatic test_async_reset();
    do_reset();
    next();
    ifc.i_a_request = 1'b1;
    ifc.i_a_address = 32'h600;
    next();
    next();
    ifc.i_bus_ready = 1'b1;
    #1;
    n_cmp++;
    if (ifc.o_bus_request !== 1'b1 || ifc.o_a_ready !== 1'b1) begin
      n_err++;
      $display("FAIL areset_pre: req=%b ardy=%b, want 1 1", ifc.o_bus_request, ifc.o_a_ready);
    end
    #1 i_reset = 1'b0;
    #1;
    n_cmp++;
    if ({ifc.o_bus_request, ifc.o_bus_address, ifc.o_a_ready, ifc.o_b_ready, ifc.o_bus_rw} !== '0) begin
      n_err++;
      $display("FAIL areset_now: req=%b addr=%h ardy=%b brdy=%b, want 0 0 0 0",
               ifc.o_bus_request, ifc.o_bus_address, ifc.o_a_ready, ifc.o_b_ready);
    end
    clr();
    @(negedge i_clock);
    i_reset = 1'b1;
    next();
    ifc.i_b_request = 1'b1;
    ifc.i_b_rw      = 1'b1;
    ifc.i_b_address = 32'h700;
    ifc.i_b_wdata   = 32'hCAFE;
    ifc.i_b_wmask   = 4'h3;
    @(negedge i_clock);
    n_cmp++;
    if (ifc.o_bus_request !== 1'b0) begin
      n_err++;
      $display("FAIL areset_after_c0: req=%b, want 0", ifc.o_bus_request);
    end
    next();
    ifc.i_bus_ready = 1'b1;
    @(negedge i_clock);
    n_cmp++;
    if ({ifc.o_bus_request, ifc.o_bus_address, ifc.o_bus_wdata, ifc.o_bus_wmask, ifc.o_b_ready}
        !== {1'b1, 32'h700, 32'hCAFE, 4'h3, 1'b1}) begin
      n_err++;
      $display("FAIL areset_after_grant: req=%b addr=%h wdata=%h wmask=%h brdy=%b, want 1 700 cafe 3 1",
               ifc.o_bus_request, ifc.o_bus_address, ifc.o_bus_wdata, ifc.o_bus_wmask, ifc.o_b_ready);
    end
    next();
    clr();
  endtask
  task automatic test_random();
    int owner, b_run, waited, pct;
    bit tmo, a_done, b_done, x_req;
    logic [136:0] exp_v, act_v;
    owner  = 0;
    b_run  = 0;
    waited = 0;
    tmo    = 0;
    a_done = 0;
    b_done = 0;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      next();
      pct = 2 + 2 * ((i / 250) % 4);
      if (ifc.i_a_request) begin
        if (a_done) begin
          if ($urandom_range(1) == 1) ifc.i_a_address = $urandom;
          else ifc.i_a_request = 1'b0;
        end else if ($urandom_range(15) == 0) ifc.i_a_request = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        ifc.i_a_request = 1'b1;
        ifc.i_a_address = $urandom;
      end
      if (ifc.i_b_request) begin
        if (b_done) begin
          if ($urandom_range(1) == 1) begin
            ifc.i_b_address = $urandom;
            ifc.i_b_wdata   = $urandom;
            ifc.i_b_rw      = 1'($urandom_range(1));
            ifc.i_b_wmask   = 4'($urandom_range(15));
          end else ifc.i_b_request = 1'b0;
        end else if ($urandom_range(15) == 0) ifc.i_b_request = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        ifc.i_b_request = 1'b1;
        ifc.i_b_address = $urandom;
        ifc.i_b_wdata   = $urandom;
        ifc.i_b_rw      = 1'($urandom_range(1));
        ifc.i_b_wmask   = 4'($urandom_range(15));
      end
      ifc.i_bus_ready = ($urandom_range(9) < pct);
      ifc.i_bus_rdata = $urandom;
      @(negedge i_clock);
      exp_v = '0;
      if (owner == 1) begin
        exp_v[136]     = ifc.i_a_request;
        exp_v[134:103] = ifc.i_a_address;
        exp_v[66]      = ifc.i_a_request & ifc.i_bus_ready;
      end else if (owner == 2) begin
        exp_v[136]     = ifc.i_b_request;
        exp_v[135]     = ifc.i_b_rw;
        exp_v[134:103] = ifc.i_b_address;
        exp_v[102:71]  = ifc.i_b_wdata;
        exp_v[70:67]   = ifc.i_b_wmask;
        exp_v[65]      = ifc.i_b_request & ifc.i_bus_ready;
      end
      exp_v[64:33] = ifc.i_bus_rdata;
      exp_v[32:1]  = ifc.i_bus_rdata;
      exp_v[0]     = tmo;
      act_v = {ifc.o_bus_request, ifc.o_bus_rw, ifc.o_bus_address, ifc.o_bus_wdata, ifc.o_bus_wmask,
               ifc.o_a_ready, ifc.o_b_ready, ifc.o_a_rdata, ifc.o_b_rdata, ifc.o_timeout};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL random_cycle%0d: got %h, want %h (owner=%0d)", i, act_v, exp_v, owner);
      end
      a_done = exp_v[66];
      b_done = exp_v[65];
      if (owner == 0) begin
        waited = 0;
        if (ifc.i_b_request && !(ifc.i_a_request && b_run >= LIMIT)) begin
          owner = 2;
          if (ifc.i_a_request) b_run++;
        end else if (ifc.i_a_request) begin
          owner = 1;
          b_run = 0;
        end
      end else begin
        x_req = (owner == 1) ? ifc.i_a_request : ifc.i_b_request;
        waited = ifc.i_bus_ready ? 0 : waited + 1;
        if (waited >= TMO) tmo = 1;
        if (ifc.i_bus_ready || !x_req) owner = 0;
      end
    end
    next();
    clr();
  endtask
  initial begin
    clr();
    test_reset();
    test_single_a();
    test_simultaneous();
    test_starvation();
    test_abort();
    test_watchdog();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
